// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, byte width, oversample midpoint
// and the even-parity helper used by the UART receive channel.
// The PARITY state exists only when RX_PARITY_EN is defined.
package uart_pkg;

  localparam int BYTE_W  = 8;
  localparam int OVS_MID = 8;

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_e;
`else
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_e;
`endif

  // Parity bit that makes the data plus parity contain an even number of ones.
  function automatic logic even_parity(input logic [BYTE_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: show-ahead byte FIFO. Pointers carry one extra wrap bit so full
// and empty are told apart without a separate count. A push into a full FIFO
// is dropped and reported on ovf unless a pop retires the head that cycle.
module rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              empty,
  output logic              ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]       wptr_r;
  logic [AW:0]       rptr_r;
  logic [BYTE_W-1:0] mem_r [DEPTH];
  logic              full_s;
  logic              do_pop_s;
  logic              do_push_s;

  assign empty     = (wptr_r == rptr_r);
  assign full_s    = (wptr_r[AW-1:0] == rptr_r[AW-1:0]) && (wptr_r[AW] != rptr_r[AW]);
  assign do_pop_s  = pop && !empty;
  // When full, a simultaneous pop frees the head slot, which is the slot written.
  assign do_push_s = push && (!full_s || do_pop_s);
  assign ovf       = push && full_s && !do_pop_s;
  assign dout      = mem_r[rptr_r[AW-1:0]];

  // Storage and pointer update; reset empties the FIFO and clears the array.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_r <= '0;
      rptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wptr_r[AW-1:0]] <= din;
        wptr_r                <= wptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_rx_channel.sv
// uart_rx_channel: one UART receive channel. The serial line is synchronised,
// oversampled at OVS ticks per bit from a programmable divisor and framed as
// 8N1; received bytes land in an rx_fifo drained one byte per i_read.
// Define RX_PARITY_EN for 8E1 frames with an o_perr pulse on parity errors.
module uart_rx_channel
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OVS   = 2 * OVS_MID
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx,
  input  logic [15:0]       i_baud,
  input  logic              i_read,
  output logic [BYTE_W-1:0] o_D,
  output logic              o_ready,
  output logic              o_used,
  output logic              o_ferr,
  output logic              o_ovf
`ifdef RX_PARITY_EN
  ,
  output logic              o_perr
`endif
);

  localparam int              TW     = $clog2(OVS);
  localparam logic [TW-1:0]   T_ONE  = TW'(1);
  localparam logic [TW-1:0]   T_HALF = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0]   T_LAST = TW'(OVS - 1);
  localparam int              BW     = $clog2(BYTE_W);
  localparam logic [BW-1:0]   B_ONE  = BW'(1);
  localparam logic [BW-1:0]   B_LAST = BW'(BYTE_W - 1);

  logic              sync1_r;
  logic              rxs_r;
  logic [15:0]       cnt_r;
  logic              tick_s;
  logic              samp_s;
  logic              stop_hit_s;
  logic              push_s;
  logic              empty_s;
  logic              fifo_ovf_s;
  logic              ferr_r;
  logic              ovf_r;
  rx_state_e         state_r;
  logic [TW-1:0]     tcnt_r;
  logic [BW-1:0]     bcnt_r;
  logic [BYTE_W-1:0] shift_r;
`ifdef RX_PARITY_EN
  logic              perr_flag_r;
  logic              perr_r;
`endif

  assign tick_s     = (cnt_r == 16'd0);
  // Whole-bit sample point used by DATA, PARITY and STOP.
  assign samp_s     = tick_s && (tcnt_r == T_LAST);
  assign stop_hit_s = (state_r == RX_STOP) && samp_s;
`ifdef RX_PARITY_EN
  assign push_s     = stop_hit_s && rxs_r && !perr_flag_r;
`else
  assign push_s     = stop_hit_s && rxs_r;
`endif

  // Two-flop synchroniser for the asynchronous line, idling high.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
    end else begin
      sync1_r <= i_rx;
      rxs_r   <= sync1_r;
    end
  end

  // Free-running divisor; a new i_baud is picked up only at reload.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_r <= 16'd0;
    end else if (tick_s) begin
      cnt_r <= i_baud;
    end else begin
      cnt_r <= cnt_r - 16'd1;
    end
  end

  // Frame state machine: start validation, data shift, parity and stop checks.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_r     <= RX_IDLE;
      tcnt_r      <= '0;
      bcnt_r      <= '0;
      shift_r     <= '0;
      ferr_r      <= 1'b0;
`ifdef RX_PARITY_EN
      perr_flag_r <= 1'b0;
      perr_r      <= 1'b0;
`endif
    end else begin
      ferr_r <= 1'b0;
`ifdef RX_PARITY_EN
      perr_r <= 1'b0;
`endif
      if (state_r != RX_IDLE && state_r != RX_START && tick_s) begin
        tcnt_r <= (tcnt_r == T_LAST) ? '0 : tcnt_r + T_ONE;
      end
      case (state_r)
        RX_IDLE: begin
          if (!rxs_r) begin
            state_r <= RX_START;
            tcnt_r  <= '0;
`ifdef RX_PARITY_EN
            perr_flag_r <= 1'b0;
`endif
          end
        end
        RX_START: begin
          if (tick_s) begin
            if (tcnt_r == T_HALF) begin
              // Mid start bit: a high line here was only a glitch.
              tcnt_r  <= '0;
              bcnt_r  <= '0;
              state_r <= rxs_r ? RX_IDLE : RX_DATA;
            end else begin
              tcnt_r <= tcnt_r + T_ONE;
            end
          end
        end
        RX_DATA: begin
          if (samp_s) begin
            shift_r <= {rxs_r, shift_r[BYTE_W-1:1]};
            bcnt_r  <= bcnt_r + B_ONE;
            if (bcnt_r == B_LAST) begin
`ifdef RX_PARITY_EN
              state_r <= RX_PARITY;
`else
              state_r <= RX_STOP;
`endif
            end
          end
        end
`ifdef RX_PARITY_EN
        RX_PARITY: begin
          if (samp_s) begin
            perr_flag_r <= (rxs_r != even_parity(shift_r));
            state_r     <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (samp_s) begin
            if (rxs_r) begin
              state_r <= RX_IDLE;
`ifdef RX_PARITY_EN
              perr_r  <= perr_flag_r;
`endif
            end else begin
              ferr_r  <= 1'b1;
              state_r <= RX_BREAK;
            end
          end
        end
        RX_BREAK: begin
          if (rxs_r) begin
            state_r <= RX_IDLE;
          end
        end
        default: begin
          state_r <= RX_IDLE;
        end
      endcase
    end
  end

  // Sticky overflow, cleared by a pop that actually retires a byte.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      ovf_r <= 1'b0;
    end else if (fifo_ovf_s) begin
      ovf_r <= 1'b1;
    end else if (i_read && !empty_s) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst),
    .push  (push_s),
    .pop   (i_read),
    .din   (shift_r),
    .dout  (o_D),
    .empty (empty_s),
    .ovf   (fifo_ovf_s)
  );

  assign o_ready = !empty_s;
  assign o_used  = (state_r != RX_IDLE);
  assign o_ferr  = ferr_r;
  assign o_ovf   = ovf_r;
`ifdef RX_PARITY_EN
  assign o_perr  = perr_r;
`endif

endmodule

// File: tb/tb_uart_rx_channel.sv
// tb_uart_rx_channel: self-checking bench for uart_rx_channel at i_baud=1
// (32 clocks per bit). Expected bytes go into a scoreboard queue when a
// frame is sent and are compared as the FIFO is drained.
`timescale 1ns/1ps
module tb_uart_rx_channel;

  localparam int BIT = 32;
`ifdef RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int STOP_LO = (NBITS - 1) * BIT + 12;
  localparam int STOP_HI = (NBITS - 1) * BIT + 28;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_rx;
  logic [15:0] i_baud;
  logic        i_read;
  logic [7:0]  o_D;
  logic        o_ready;
  logic        o_used;
  logic        o_ferr;
  logic        o_ovf;
`ifdef RX_PARITY_EN
  logic        o_perr;
`endif

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    bit         good_stop;
    bit         push;
    int         ferr;
  } vec_t;
  vec_t vecs[6];

  uart_rx_channel #(.DEPTH(4), .OVS(16)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_rx    (i_rx),
    .i_baud  (i_baud),
    .i_read  (i_read),
    .o_D     (o_D),
    .o_ready (o_ready),
    .o_used  (o_used),
    .o_ferr  (o_ferr),
    .o_ovf   (o_ovf)
`ifdef RX_PARITY_EN
    ,
    .o_perr  (o_perr)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Count error-pulse cycles; a single-cycle pulse adds exactly one.
  always @(negedge i_clk) begin
    if (o_ferr) ferr_cnt <= ferr_cnt + 1;
`ifdef RX_PARITY_EN
    if (o_perr) perr_cnt <= perr_cnt + 1;
`endif
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one frame bit-time by bit-time; optionally pulse i_read at cycle
  // read_at. Reports the cycle o_used fell and the cycle o_ready rose.
  task automatic send_frame(input logic [7:0] data, input bit good_stop, input bit good_par,
                            input int read_at, output int used_fall, output int ready_rise);
    logic seq[$];
    logic prev_used;
    logic prev_ready;
    logic par_bit;
    par_bit = good_par ? ^data : ~^data;
    seq.push_back(1'b0);
    for (int i = 0; i < 8; i++) seq.push_back(data[i]);
`ifdef RX_PARITY_EN
    seq.push_back(par_bit);
`endif
    if (!good_stop) begin
      seq.push_back(1'b0);
      seq.push_back(1'b0);
    end
    seq.push_back(1'b1);
    seq.push_back(1'b1);
    used_fall  = -1;
    ready_rise = -1;
    prev_used  = 1'b0;
    prev_ready = 1'b0;
    for (int c = 0; c < seq.size() * BIT; c++) begin
      @(negedge i_clk);
      if (c > 0) begin
        if (prev_used && !o_used && used_fall < 0) used_fall = c;
        if (!prev_ready && o_ready && ready_rise < 0) ready_rise = c;
      end
      prev_used  = o_used;
      prev_ready = o_ready;
      i_rx   = seq[c / BIT];
      i_read = (c == read_at);
    end
  endtask

  // Pop every expected byte, comparing the head before each pop.
  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 16) begin
      guard++;
      check({name, "_ready"}, {31'd0, o_ready}, 32'd1);
      check({name, "_data"}, {24'd0, o_D}, {24'd0, exp_q.pop_front()});
      i_read = 1'b1;
      @(negedge i_clk);
      i_read = 1'b0;
    end
    check({name, "_empty"}, {31'd0, o_ready}, 32'd0);
  endtask

  initial begin
    int uf;
    int rr;
    int uf_prev;
    int fb;
    bit used_seen;
    logic [7:0] partial;

    vecs[0] = '{8'h00, 1'b1, 1'b1, 0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 0};
    vecs[2] = '{8'h80, 1'b1, 1'b1, 0};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 1};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 0};
    vecs[5] = '{8'h3C, 1'b1, 1'b1, 0};

    i_rst = 1'b0; i_rx = 1'b1; i_baud = 16'd1; i_read = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_D", {24'd0, o_D}, 32'd0);
    check("rst_ready", {31'd0, o_ready}, 32'd0);
    check("rst_used", {31'd0, o_used}, 32'd0);
    check("rst_ferr", {31'd0, o_ferr}, 32'd0);
    check("rst_ovf", {31'd0, o_ovf}, 32'd0);
`ifdef RX_PARITY_EN
    check("rst_perr", {31'd0, o_perr}, 32'd0);
`endif
    i_rst = 1'b1;
    repeat (4) @(negedge i_clk);

    // Normal byte and its latency relative to the stop sample.
    send_frame(8'h41, 1'b1, 1'b1, -1, uf, rr);
    check("norm_stop_window", {31'd0, (uf >= STOP_LO && uf <= STOP_HI)}, 32'd1);
    check("norm_ready_lat", rr, uf);
    exp_q.push_back(8'h41);
    drain("norm");

    // Glitch shorter than half a bit.
    fb = ferr_cnt;
    used_seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge i_clk);
      if (o_used) used_seen = 1'b1;
      i_rx = (c < 12) ? 1'b0 : 1'b1;
    end
    check("glitch_used_seen", {31'd0, used_seen}, 32'd1);
    check("glitch_used_end", {31'd0, o_used}, 32'd0);
    check("glitch_ready", {31'd0, o_ready}, 32'd0);
    check("glitch_ovf", {31'd0, o_ovf}, 32'd0);
    check("glitch_ferr", ferr_cnt - fb, 32'd0);

    // Framing error then recovery.
    fb = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b1, -1, uf, rr);
    check("ferr_pulse", ferr_cnt - fb, 32'd1);
    check("ferr_empty", {31'd0, o_ready}, 32'd0);
    send_frame(8'hA3, 1'b1, 1'b1, -1, uf, rr);
    exp_q.push_back(8'hA3);
    drain("after_ferr");

    // Table of mixed frames.
    for (int v = 0; v < 6; v++) begin
      fb = ferr_cnt;
      send_frame(vecs[v].data, vecs[v].good_stop, 1'b1, -1, uf, rr);
      if (vecs[v].push) exp_q.push_back(vecs[v].data);
      check($sformatf("vec%0d_ferr", v), ferr_cnt - fb, vecs[v].ferr);
      drain($sformatf("vec%0d", v));
    end

    // Overflow: five bytes into four entries.
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b1, 1'b1, -1, uf, rr);
      if (k <= 4) exp_q.push_back(8'(k));
      if (k == 4) check("full_no_ovf_yet", {31'd0, o_ovf}, 32'd0);
    end
    check("ovf_set", {31'd0, o_ovf}, 32'd1);
    check("ovf_head", {24'd0, o_D}, {24'd0, exp_q.pop_front()});
    i_read = 1'b1;
    @(negedge i_clk);
    i_read = 1'b0;
    check("ovf_cleared", {31'd0, o_ovf}, 32'd0);
    drain("ovf");

    // Push and pop on the same cycle while full.
    uf_prev = -1;
    for (int k = 0; k < 4; k++) begin
      send_frame(8'h11 + 8'(k), 1'b1, 1'b1, -1, uf_prev, rr);
      exp_q.push_back(8'h11 + 8'(k));
    end
    check("fullrd_head", {24'd0, o_D}, {24'd0, exp_q.pop_front()});
    send_frame(8'h15, 1'b1, 1'b1, uf_prev - 1, uf, rr);
    check("fullrd_same_cycle", uf, uf_prev);
    exp_q.push_back(8'h15);
    check("fullrd_no_ovf", {31'd0, o_ovf}, 32'd0);
    drain("fullrd");

    // Reset in the middle of a frame with a byte still queued.
    send_frame(8'h22, 1'b1, 1'b1, -1, uf, rr);
    partial = 8'h99;
    for (int c = 0; c < 5 * BIT; c++) begin
      @(negedge i_clk);
      i_rx = (c < BIT) ? 1'b0 : partial[(c / BIT) - 1];
    end
    check("mid_used", {31'd0, o_used}, 32'd1);
    check("mid_ready", {31'd0, o_ready}, 32'd1);
    i_rst = 1'b0;
    i_rx  = 1'b1;
    @(negedge i_clk);
    check("mrst_D", {24'd0, o_D}, 32'd0);
    check("mrst_ready", {31'd0, o_ready}, 32'd0);
    check("mrst_used", {31'd0, o_used}, 32'd0);
    check("mrst_ovf", {31'd0, o_ovf}, 32'd0);
    i_rst = 1'b1;
    exp_q.delete();
    repeat (2 * BIT) @(negedge i_clk);
    check("mrst_idle", {31'd0, o_used}, 32'd0);
    send_frame(8'h6B, 1'b1, 1'b1, -1, uf, rr);
    exp_q.push_back(8'h6B);
    drain("post_rst");

`ifdef RX_PARITY_EN
    // Wrong parity bit: one o_perr pulse, nothing stored.
    fb = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b0, -1, uf, rr);
    check("perr_pulse", perr_cnt - fb, 32'd1);
    check("perr_empty", {31'd0, o_ready}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
